// File: rtl/pipe_dbg_pkg.sv
// Shared constants, state encoding and the command decoder for the pipeline debug sequencer.
package pipe_dbg_pkg;

  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_PAUSE = 8'h70;
  localparam logic [7:0] CMD_DUMP  = 8'h64;

  // ST_ECHO is only reachable when DBG_ECHO_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ECHO = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  typedef struct packed {
    state_t nxt;
    logic   set_run;
    logic   clr_run;
  } cmd_act_t;

  // IDX_W: width of the dump byte index for a given word count.
  function automatic int idx_w(input int num_words);
    return $clog2(num_words * 4);
  endfunction

  function automatic cmd_act_t decode_cmd(input logic [7:0] b);
    cmd_act_t a;
    a = '{nxt: ST_IDLE, set_run: 1'b0, clr_run: 1'b0};
    case (b)
      CMD_STEP:  begin a.nxt = ST_STEP; a.clr_run = 1'b1; end
      CMD_RUN:   a.set_run = 1'b1;
      CMD_PAUSE: a.clr_run = 1'b1;
      CMD_DUMP:  a.nxt = ST_DUMP;
      default:   ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/pipeline_debug_sequencer_if.sv
// Bundle of command, FIFO, snapshot and pipeline-control signals around the debug sequencer.
// rx_data is valid only in the cycle rx_data_rdy=1; a push happens in any cycle with fifo_wr_en=1, which is never asserted while fifo_full=1.
interface pipeline_debug_sequencer_if #(parameter int NUM_WORDS = 8);
  import pipe_dbg_pkg::*;

  logic [7:0]              rx_data;
  logic                    rx_data_rdy;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [7:0]              fifo_din;
  logic [NUM_WORDS*32-1:0] snapshot;
  logic                    pipe_clk_en;
  logic                    running;
  logic                    busy;
  state_t                  dbg_state;

  modport slave (
    input  rx_data, rx_data_rdy, fifo_full, snapshot,
    output fifo_wr_en, fifo_din, pipe_clk_en, running, busy, dbg_state
  );

  modport master (
    output rx_data, rx_data_rdy, fifo_full, snapshot,
    input  fifo_wr_en, fifo_din, pipe_clk_en, running, busy, dbg_state
  );
endinterface

// File: rtl/dbg_byte_serializer.sv
// Shadow copy of the snapshot plus byte index; presents word 0 first, each word MSB byte first.
module dbg_byte_serializer
  import pipe_dbg_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_advance,
  input  logic [NUM_WORDS*32-1:0] i_snapshot,
  output logic [7:0]              o_byte,
  output logic                    o_last
);
  localparam int NBYTES = NUM_WORDS * 4;
  localparam int IDX_W  = idx_w(NUM_WORDS);

  logic [NUM_WORDS*32-1:0] r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic [7:0]              w_bytes [NBYTES];

  for (genvar gb = 0; gb < NBYTES; gb++) begin : g_bytes
    assign w_bytes[gb] = r_shadow[32*(gb/4) + 31 - 8*(gb%4) -: 8];
  end

  assign o_byte = w_bytes[r_idx];
  assign o_last = (r_idx == IDX_W'(NBYTES - 1));

  // Index wraps to 0 on the final byte so the next dump starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_idx    <= '0;
    end else if (i_load) begin
      r_shadow <= i_snapshot;
      r_idx    <= '0;
    end else if (i_advance) begin
      r_idx <= o_last ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_debug_sequencer.sv
// Run/step/dump controller: decodes UART command bytes, gates the pipeline clock enable and
// serialises a latched snapshot into the tx FIFO. Optional feature macro: DBG_ECHO_EN (echo every command byte).
module pipeline_debug_sequencer
  import pipe_dbg_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_debug_sequencer_if.slave    bus
);
  state_t     r_state, w_state_next;
  logic       r_running, w_running_next;
  logic       w_load, w_advance, w_take;
  logic       w_wr_en;
  logic [7:0] w_din, w_byte, w_cmd_byte;
  logic       w_last;
  cmd_act_t   w_act;

`ifdef DBG_ECHO_EN
  logic [7:0] r_cmd;

  always_ff @(posedge clk) begin
    if (rst) r_cmd <= 8'h00;
    else if (r_state == ST_IDLE && bus.rx_data_rdy) r_cmd <= bus.rx_data;
  end

  // The command acts once its echo has been pushed.
  assign w_cmd_byte = r_cmd;
  assign w_take     = (r_state == ST_ECHO) && !bus.fifo_full;
`else
  assign w_cmd_byte = bus.rx_data;
  assign w_take     = (r_state == ST_IDLE) && bus.rx_data_rdy;
`endif

  assign w_act = decode_cmd(w_cmd_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= w_running_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_running_next = r_running;
    w_load         = 1'b0;
    w_advance      = 1'b0;
    w_wr_en        = 1'b0;
    w_din          = 8'h00;
    case (r_state)
      ST_IDLE: begin
`ifdef DBG_ECHO_EN
        if (bus.rx_data_rdy) w_state_next = ST_ECHO;
`endif
      end
`ifdef DBG_ECHO_EN
      ST_ECHO: begin
        w_din = r_cmd;
        if (!bus.fifo_full) w_wr_en = 1'b1;
      end
`endif
      ST_STEP: w_state_next = ST_IDLE;
      ST_DUMP: begin
        w_din = w_byte;
        if (!bus.fifo_full) begin
          w_wr_en   = 1'b1;
          w_advance = 1'b1;
          if (w_last) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_take) begin
      w_state_next = w_act.nxt;
      w_load       = (w_act.nxt == ST_DUMP);
      if (w_act.set_run) w_running_next = 1'b1;
      if (w_act.clr_run) w_running_next = 1'b0;
    end
  end

  dbg_byte_serializer #(.NUM_WORDS(NUM_WORDS)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_advance  (w_advance),
    .i_snapshot (bus.snapshot),
    .o_byte     (w_byte),
    .o_last     (w_last)
  );

  // Free-run is frozen (not cleared) while busy, so it resumes after a dump.
  assign bus.pipe_clk_en = (r_running && r_state == ST_IDLE) || (r_state == ST_STEP);
  assign bus.running     = r_running;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.fifo_wr_en  = w_wr_en;
  assign bus.fifo_din    = w_din;
  assign bus.dbg_state   = r_state;

endmodule
